// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serial memory controller: FSM states, owners,
// LOAD/STORE tags, size codes, IO base and small byte helpers.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWNER_LSB = 1'b0,
        OWNER_IF  = 1'b1
    } owner_t;

    localparam logic TAG_LOAD  = 1'b0;
    localparam logic TAG_STORE = 1'b1;

    localparam logic [2:0] SIZE_B = 3'b001;
    localparam logic [2:0] SIZE_H = 3'b010;
    localparam logic [2:0] SIZE_W = 3'b100;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

    // Byte count of an LSB request; unknown encodings fall back to a full word.
    function automatic logic [2:0] size_to_n(input logic [2:0] size);
        case (size)
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] idx);
        case (idx)
            2'd0:    return word[7:0];
            2'd1:    return word[15:8];
            2'd2:    return word[23:16];
            default: return word[31:24];
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response and RAM-bus bundle for mem_ctrl. The slave modport is the
// controller's view; master is the requesters plus RAM/IO side.
interface mem_ctrl_if;
    // Handshake: a requester raises *_enable with stable fields and holds it until
    // the matching one-cycle *_success pulse; that pulse is the only acknowledge,
    // so each held request is transferred exactly once.
    logic        lsb_enable;
    logic        lsb_wr_tag;
    logic [2:0]  lsb_size;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_wdata;
    logic        lsb_success;
    logic [31:0] lsb_rdata;

    logic        if_enable;
    logic [31:0] if_addr;
    logic        if_success;
    logic [31:0] if_rdata;

    logic        io_buffer_full;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    modport slave (
        input  lsb_enable, lsb_wr_tag, lsb_size, lsb_addr, lsb_wdata,
        output lsb_success, lsb_rdata,
        input  if_enable, if_addr,
        output if_success, if_rdata,
        input  io_buffer_full, mem_din,
        output mem_dout, mem_a, mem_wr
    );

    modport master (
        output lsb_enable, lsb_wr_tag, lsb_size, lsb_addr, lsb_wdata,
        input  lsb_success, lsb_rdata,
        output if_enable, if_addr,
        input  if_success, if_rdata,
        output io_buffer_full, mem_din,
        input  mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_ctrl_byte_seq.sv
// Byte sequencer: holds base address, byte count and store data of the active
// transaction, steps the byte index k and assembles little-endian read data.
module mem_ctrl_byte_seq
    import mem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        start,
    input  logic [31:0] start_addr,
    input  logic [2:0]  start_n,
    input  logic [31:0] start_wdata,
    input  logic        advance,
    input  logic        capture,
    input  logic [7:0]  din,
    output logic [31:0] issue_addr,
    output logic [7:0]  issue_byte,
    output logic        issue_valid,
    output logic        write_last,
    output logic        read_last,
    output logic [31:0] read_word
);

    logic [31:0] base_q;
    logic [31:0] wdata_q;
    logic [31:0] asm_q;
    logic [2:0]  n_q;
    logic [2:0]  k_q;
    logic [2:0]  k_inc;
    logic [1:0]  cap_lane;

    // k counts edges since accept: the edge that bumps k to j issues byte j and,
    // because the RAM answers one edge late, captures byte j-2.
    assign k_inc       = k_q + 3'd1;
    assign issue_addr  = base_q + {29'd0, k_inc};
    assign issue_byte  = byte_lane(wdata_q, k_inc[1:0]);
    assign issue_valid = (k_inc < n_q);
    assign write_last  = (k_inc == n_q);
    assign read_last   = (k_q == n_q);
    assign cap_lane    = k_q[1:0] - 2'd1;

    always_comb begin
        read_word = asm_q;
        read_word[{cap_lane, 3'b000} +: 8] = din;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            base_q  <= 32'd0;
            wdata_q <= 32'd0;
            asm_q   <= 32'd0;
            n_q     <= 3'd0;
            k_q     <= 3'd0;
        end else if (rdy) begin
            if (start) begin
                base_q  <= start_addr;
                wdata_q <= start_wdata;
                asm_q   <= 32'd0;
                n_q     <= start_n;
                k_q     <= 3'd0;
            end else if (advance) begin
                k_q <= k_inc;
                if (capture && (k_q != 3'd0)) begin
                    asm_q <= read_word;
                end
            end
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates LSB and fetch onto the 8-bit bus,
// handles fetch flush and routes completion pulses. Optional IO stall under
// MEM_CTRL_IO_STALL_EN.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rdy,
    input  logic      jump_flag,
    mem_ctrl_if.slave bus,
    output state_t    dbg_state
);

    state_t      state_q, state_n;
    owner_t      owner_q, owner_n;
    logic [31:0] mem_a_q, mem_a_n;
    logic [7:0]  mem_dout_q, mem_dout_n;
    logic        mem_wr_q, mem_wr_n;
    logic        lsb_success_q, lsb_success_n;
    logic        if_success_q, if_success_n;
    logic [31:0] lsb_rdata_q, lsb_rdata_n;
    logic [31:0] if_rdata_q, if_rdata_n;

    logic        seq_start;
    logic        seq_advance;
    logic        seq_capture;
    logic [31:0] seq_addr;
    logic [2:0]  seq_n;
    logic [31:0] seq_wdata;
    logic [31:0] seq_issue_addr;
    logic [7:0]  seq_issue_byte;
    logic        seq_issue_valid;
    logic        seq_write_last;
    logic        seq_read_last;
    logic [31:0] seq_read_word;

    logic        lsb_blocked;
    logic        wr_stall;

`ifdef MEM_CTRL_IO_STALL_EN
    assign lsb_blocked = bus.io_buffer_full && (bus.lsb_addr >= IO_BASE);
    assign wr_stall    = bus.io_buffer_full && (seq_issue_addr >= IO_BASE);
`else
    logic unused_io;
    assign lsb_blocked = 1'b0;
    assign wr_stall    = 1'b0;
    assign unused_io   = bus.io_buffer_full | (|IO_BASE);
`endif

    mem_ctrl_byte_seq u_seq (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .start       (seq_start),
        .start_addr  (seq_addr),
        .start_n     (seq_n),
        .start_wdata (seq_wdata),
        .advance     (seq_advance),
        .capture     (seq_capture),
        .din         (bus.mem_din),
        .issue_addr  (seq_issue_addr),
        .issue_byte  (seq_issue_byte),
        .issue_valid (seq_issue_valid),
        .write_last  (seq_write_last),
        .read_last   (seq_read_last),
        .read_word   (seq_read_word)
    );

    always_comb begin
        state_n       = state_q;
        owner_n       = owner_q;
        mem_a_n       = mem_a_q;
        mem_dout_n    = mem_dout_q;
        mem_wr_n      = 1'b0;
        lsb_success_n = 1'b0;
        if_success_n  = 1'b0;
        lsb_rdata_n   = lsb_rdata_q;
        if_rdata_n    = if_rdata_q;
        seq_start     = 1'b0;
        seq_advance   = 1'b0;
        seq_capture   = 1'b0;
        seq_addr      = bus.lsb_addr;
        seq_n         = size_to_n(bus.lsb_size);
        seq_wdata     = bus.lsb_wdata;

        unique case (state_q)
            ST_IDLE: begin
                // LSB wins ties; jump_flag only gates fetch acceptance.
                if (bus.lsb_enable && !lsb_blocked) begin
                    owner_n   = OWNER_LSB;
                    seq_start = 1'b1;
                    mem_a_n   = bus.lsb_addr;
                    if (bus.lsb_wr_tag == TAG_STORE) begin
                        mem_dout_n = bus.lsb_wdata[7:0];
                        mem_wr_n   = 1'b1;
                        state_n    = ST_WRITE;
                    end else begin
                        state_n = ST_READ;
                    end
                end else if (bus.if_enable && !jump_flag) begin
                    owner_n   = OWNER_IF;
                    seq_start = 1'b1;
                    seq_addr  = bus.if_addr;
                    seq_n     = 3'd4;
                    seq_wdata = 32'd0;
                    mem_a_n   = bus.if_addr;
                    state_n   = ST_READ;
                end
            end
            ST_READ: begin
                if ((owner_q == OWNER_IF) && jump_flag) begin
                    state_n = ST_IDLE;
                end else begin
                    seq_advance = 1'b1;
                    seq_capture = 1'b1;
                    if (seq_issue_valid) begin
                        mem_a_n = seq_issue_addr;
                    end
                    if (seq_read_last) begin
                        state_n = ST_DONE;
                        if (owner_q == OWNER_LSB) begin
                            lsb_rdata_n   = seq_read_word;
                            lsb_success_n = 1'b1;
                        end else begin
                            if_rdata_n   = seq_read_word;
                            if_success_n = 1'b1;
                        end
                    end
                end
            end
            ST_WRITE: begin
                if (seq_write_last) begin
                    state_n       = ST_DONE;
                    lsb_success_n = 1'b1;
                end else if (!wr_stall) begin
                    seq_advance = 1'b1;
                    mem_a_n     = seq_issue_addr;
                    mem_dout_n  = seq_issue_byte;
                    mem_wr_n    = 1'b1;
                end
            end
            ST_DONE: begin
                // Dead cycle: the requester drops its enable before IDLE looks again.
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            owner_q       <= OWNER_LSB;
            mem_a_q       <= 32'd0;
            mem_dout_q    <= 8'd0;
            mem_wr_q      <= 1'b0;
            lsb_success_q <= 1'b0;
            if_success_q  <= 1'b0;
            lsb_rdata_q   <= 32'd0;
            if_rdata_q    <= 32'd0;
        end else if (rdy) begin
            state_q       <= state_n;
            owner_q       <= owner_n;
            mem_a_q       <= mem_a_n;
            mem_dout_q    <= mem_dout_n;
            mem_wr_q      <= mem_wr_n;
            lsb_success_q <= lsb_success_n;
            if_success_q  <= if_success_n;
            lsb_rdata_q   <= lsb_rdata_n;
            if_rdata_q    <= if_rdata_n;
        end
    end

    assign bus.mem_a       = mem_a_q;
    assign bus.mem_dout    = mem_dout_q;
    assign bus.mem_wr      = mem_wr_q;
    assign bus.lsb_success = lsb_success_q;
    assign bus.lsb_rdata   = lsb_rdata_q;
    assign bus.if_success  = if_success_q;
    assign bus.if_rdata    = if_rdata_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a one-edge-latency byte RAM model.
// Expected values are hand-computed; honours MEM_CTRL_IO_STALL_EN for the IO step.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    logic   rdy = 1'b1;
    logic   jump_flag = 1'b0;
    state_t dbg_state;

    mem_ctrl_if bus ();

    mem_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .jump_flag (jump_flag),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- RAM model ----------------
    logic [7:0] wmem [logic [31:0]];
    int         wr_cnt = 0;

    function automatic logic [7:0] pat(input logic [31:0] a);
        case (a)
            32'h100: return 8'h11;
            32'h101: return 8'h22;
            32'h102: return 8'h33;
            32'h103: return 8'h44;
            32'h010: return 8'h80;
            default: return a[7:0] ^ a[15:8] ^ 8'hA5;
        endcase
    endfunction

    function logic [7:0] ram_rd(input logic [31:0] a);
        if (wmem.exists(a)) return wmem[a];
        return pat(a);
    endfunction

    always @(posedge clk) begin
        bus.mem_din <= ram_rd(bus.mem_a);
        if (bus.mem_wr) begin
            wmem[bus.mem_a] = bus.mem_dout;
            wr_cnt++;
        end
    end

    // ---------------- pulse monitors ----------------
    int lsb_cnt = 0;
    int if_cnt = 0;
    int both_cnt = 0;

    always @(posedge clk) begin
        if (bus.lsb_success) lsb_cnt++;
        if (bus.if_success) if_cnt++;
        if (bus.lsb_success && bus.if_success) both_cnt++;
    end

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    logic [31:0] a_trace[$];
    logic        w_trace[$];
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic present_lsb(input logic wr, input logic [2:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata);
        bus.lsb_enable = 1'b1;
        bus.lsb_wr_tag = wr;
        bus.lsb_size   = size;
        bus.lsb_addr   = addr;
        bus.lsb_wdata  = wdata;
    endtask

    // t counts negedges from request presentation; the accept edge falls before t=1.
    task automatic wait_lsb(input int t0, output int t);
        t = t0;
        a_trace.delete();
        w_trace.delete();
        while (!bus.lsb_success && t < 40) begin
            @(negedge clk);
            t++;
            a_trace.push_back(bus.mem_a);
            w_trace.push_back(bus.mem_wr);
        end
        check("lsb_done", 32'(bus.lsb_success), 32'd1);
    endtask

    task automatic wait_if(output int t);
        t = 0;
        while (!bus.if_success && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("if_done", 32'(bus.if_success), 32'd1);
        bus.if_enable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int t;
        int c0;
        int busy;

        bus.lsb_enable     = 1'b0;
        bus.lsb_wr_tag     = TAG_LOAD;
        bus.lsb_size       = SIZE_W;
        bus.lsb_addr       = 32'd0;
        bus.lsb_wdata      = 32'd0;
        bus.if_enable      = 1'b0;
        bus.if_addr        = 32'd0;
        bus.io_buffer_full = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
        check("rst_mem_a", bus.mem_a, 32'd0);
        check("rst_lsb_success", 32'(bus.lsb_success), 32'd0);
        check("rst_if_success", 32'(bus.if_success), 32'd0);
        check("rst_lsb_rdata", bus.lsb_rdata, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // LW @0x100
        exp_q.push_back(32'h4433_2211);
        present_lsb(TAG_LOAD, SIZE_W, 32'h100, 32'd0);
        wait_lsb(0, t);
        bus.lsb_enable = 1'b0;
        check("lw_lat", 32'(t), 32'd6);
        for (int i = 0; i < 4; i++) check("lw_mem_a", a_trace[i], 32'h100 + 32'(i));
        check("lw_rdata", bus.lsb_rdata, exp_q.pop_front());
        repeat (2) @(negedge clk);

        // Undefined size code behaves as a word
        exp_q.push_back(32'h4433_2211);
        present_lsb(TAG_LOAD, 3'b000, 32'h100, 32'd0);
        wait_lsb(0, t);
        bus.lsb_enable = 1'b0;
        check("size0_lat", 32'(t), 32'd6);
        check("size0_rdata", bus.lsb_rdata, exp_q.pop_front());
        repeat (2) @(negedge clk);

        // SH @0x200
        c0 = wr_cnt;
        present_lsb(TAG_STORE, SIZE_H, 32'h200, 32'hDEAD_BEEF);
        wait_lsb(0, t);
        bus.lsb_enable = 1'b0;
        check("sh_lat", 32'(t), 32'd3);
        check("sh_wr0", 32'(w_trace[0]), 32'd1);
        check("sh_wr1", 32'(w_trace[1]), 32'd1);
        check("sh_wr2", 32'(w_trace[2]), 32'd0);
        check("sh_a1", a_trace[1], 32'h201);
        check("sh_wr_cnt", 32'(wr_cnt - c0), 32'd2);
        check("sh_b0", 32'(ram_rd(32'h200)), 32'hEF);
        check("sh_b1", 32'(ram_rd(32'h201)), 32'hBE);
        check("sh_b2_untouched", 32'(wmem.exists(32'h202)), 32'd0);
        repeat (2) @(negedge clk);

        // LH @0x102 with enable held through the DONE cycle
        c0 = lsb_cnt;
        exp_q.push_back(32'h0000_4433);
        present_lsb(TAG_LOAD, SIZE_H, 32'h102, 32'd0);
        wait_lsb(0, t);
        check("lh_lat", 32'(t), 32'd4);
        check("lh_rdata", bus.lsb_rdata, exp_q.pop_front());
        @(negedge clk);
        bus.lsb_enable = 1'b0;
        busy = 0;
        repeat (3) begin
            @(negedge clk);
            if (dbg_state != ST_IDLE) busy++;
        end
        check("hold_no_reaccess", 32'(busy), 32'd0);
        check("hold_one_pulse", 32'(lsb_cnt - c0), 32'd1);

        // Both requesters at once: LB @0x10 first, then fetch @0x40
        c0 = if_cnt;
        bus.if_enable = 1'b1;
        bus.if_addr   = 32'h40;
        exp_q.push_back(32'h0000_0080);
        exp_q.push_back(32'hE6E7_E4E5);
        present_lsb(TAG_LOAD, SIZE_B, 32'h10, 32'd0);
        wait_lsb(0, t);
        bus.lsb_enable = 1'b0;
        check("arb_lb_lat", 32'(t), 32'd3);
        check("arb_lb_rdata", bus.lsb_rdata, exp_q.pop_front());
        check("arb_if_waits", 32'(bus.if_success), 32'd0);
        wait_if(t);
        check("arb_if_lat", 32'(t), 32'd7);
        check("arb_if_rdata", bus.if_rdata, exp_q.pop_front());
        repeat (2) @(negedge clk);
        check("arb_if_one_pulse", 32'(if_cnt - c0), 32'd1);

        // Fetch @0x1000 flushed in its 2nd READ cycle, then fetch @0x2000
        c0 = if_cnt;
        bus.if_addr   = 32'h1000;
        bus.if_enable = 1'b1;
        @(negedge clk);
        check("jmp_read", 32'(dbg_state), 32'(ST_READ));
        @(negedge clk);
        jump_flag = 1'b1;
        @(negedge clk);
        check("jmp_idle", 32'(dbg_state), 32'(ST_IDLE));
        check("jmp_mem_wr", 32'(bus.mem_wr), 32'd0);
        check("jmp_no_success", 32'(bus.if_success), 32'd0);
        check("jmp_rdata_kept", bus.if_rdata, 32'hE6E7_E4E5);
        jump_flag   = 1'b0;
        bus.if_addr = 32'h2000;
        exp_q.push_back(32'h8687_8485);
        wait_if(t);
        check("refetch_lat", 32'(t), 32'd6);
        check("refetch_rdata", bus.if_rdata, exp_q.pop_front());
        repeat (2) @(negedge clk);
        check("jmp_one_pulse", 32'(if_cnt - c0), 32'd1);

        // SB to IO space while the UART FIFO reports full
        c0 = wr_cnt;
        bus.io_buffer_full = 1'b1;
        present_lsb(TAG_STORE, SIZE_B, 32'h0003_0000, 32'h0000_005A);
        t = 0;
`ifdef MEM_CTRL_IO_STALL_EN
        repeat (3) begin
            @(negedge clk);
            t++;
            check("io_stall_wr", 32'(bus.mem_wr), 32'd0);
        end
        bus.io_buffer_full = 1'b0;
        wait_lsb(t, t);
        check("io_lat", 32'(t), 32'd5);
`else
        wait_lsb(0, t);
        check("io_lat", 32'(t), 32'd2);
        check("io_wr_on_accept", 32'(w_trace[0]), 32'd1);
`endif
        bus.lsb_enable     = 1'b0;
        bus.io_buffer_full = 1'b0;
        check("io_wr_cnt", 32'(wr_cnt - c0), 32'd1);
        check("io_data", 32'(ram_rd(32'h0003_0000)), 32'h5A);
        repeat (2) @(negedge clk);

        // SW @0x400 with rdy low for two edges
        present_lsb(TAG_STORE, SIZE_W, 32'h400, 32'h1122_3344);
        @(negedge clk);
        rdy = 1'b0;
        repeat (2) @(negedge clk);
        rdy = 1'b1;
        wait_lsb(3, t);
        bus.lsb_enable = 1'b0;
        check("rdy_lat", 32'(t), 32'd7);
        check("rdy_sw_data", {ram_rd(32'h403), ram_rd(32'h402), ram_rd(32'h401), ram_rd(32'h400)},
              32'h1122_3344);
        repeat (2) @(negedge clk);

        // Reset in the middle of SW @0x500
        c0 = lsb_cnt;
        present_lsb(TAG_STORE, SIZE_W, 32'h500, 32'hAABB_CCDD);
        repeat (2) @(negedge clk);
        check("mid_wr_active", 32'(bus.mem_wr), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        bus.lsb_enable = 1'b0;
        check("mid_rst_mem_wr", 32'(bus.mem_wr), 32'd0);
        check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("mid_rst_rdata", bus.lsb_rdata, 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_no_pulse", 32'(lsb_cnt - c0), 32'd0);
        check("mid_rst_b2", 32'(wmem.exists(32'h502)), 32'd0);

        check("never_both", 32'(both_cnt), 32'd0);
        check("lsb_pulses", 32'(lsb_cnt), 32'd7);
        check("if_pulses", 32'(if_cnt), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
